// File: rtl/myproject_udiv_9ns_8ns_9_seq.sv
// myproject_udiv_9ns_8ns_9_seq: sequential radix-2 restoring unsigned divider, one quotient bit per cycle
// Operand pair in via valid/ready; result held in DONE until the consumer accepts it.
module myproject_udiv_9ns_8ns_9_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 8,
  parameter int quot_WIDTH = din0_WIDTH,
  parameter int rem_WIDTH = din1_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [quot_WIDTH-1:0] quot,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  div_by_zero
);
  localparam int W = din0_WIDTH;
  localparam int D = din1_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  if (quot_WIDTH != W || rem_WIDTH != D || ID < 0) begin : g_bad_params
    $error("udiv: quot_WIDTH/rem_WIDTH must equal din0_WIDTH/din1_WIDTH");
  end
  logic [1:0]    r_state;
  logic [W-1:0]  r_dividend;
  logic [W-1:0]  r_quot;
  logic [D-1:0]  r_divisor;
  logic [D-1:0]  r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_dbz;
  logic [D:0]    w_shift;
  logic          w_ge;
  logic          w_zero;
  logic          w_accept;
  // Partial remainder is widened to D+1 bits only for the compare/subtract.
  assign w_shift = {r_rem, r_dividend[W-1]};
  assign w_ge = w_shift >= {1'b0, r_divisor};
  assign w_zero = din1 == '0;
  assign w_accept = din_valid && r_state == S_IDLE;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_dividend <= '0;
      r_divisor <= '0;
      r_rem <= '0;
      r_quot <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= din0;
      r_divisor <= din1;
      r_rem <= w_zero ? din0[D-1:0] : '0;
      r_quot <= w_zero ? '1 : '0;
      r_cnt <= w_zero ? CW'(1) : CW'(W);
      r_dbz <= w_zero;
      r_state <= S_BUSY;
    end else if (r_state == S_BUSY) begin
      // Divide-by-zero spends one idle BUSY cycle with its result preloaded.
      if (!r_dbz) begin
        r_rem <= w_ge ? D'(w_shift - {1'b0, r_divisor}) : w_shift[D-1:0];
        r_dividend <= r_dividend << 1;
        r_quot <= {r_quot[W-2:0], w_ge};
      end
      r_cnt <= r_cnt - CW'(1);
      r_state <= r_cnt == CW'(1) ? S_DONE : S_BUSY;
    end else if (r_state == S_DONE && dout_ready) begin
      r_state <= S_IDLE;
    end
  end
  assign din_ready = r_state == S_IDLE;
  assign dout_valid = r_state == S_DONE;
  assign quot = r_quot;
  assign rem = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_myproject_udiv_9ns_8ns_9_seq.sv
// tb_myproject_udiv_9ns_8ns_9_seq: scoreboard bench for the sequential unsigned divider
module tb_myproject_udiv_9ns_8ns_9_seq;
  typedef struct packed {
    logic [8:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;
  logic       ap_clk;
  logic       ap_rst;
  logic       din_valid;
  logic       din_ready;
  logic [8:0] din0;
  logic [7:0] din1;
  logic       dout_valid;
  logic       dout_ready;
  logic [8:0] quot;
  logic [7:0] rem;
  logic       div_by_zero;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  myproject_udiv_9ns_8ns_9_seq dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din0(din0),
    .din1(din1),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .quot(quot),
    .rem(rem),
    .div_by_zero(div_by_zero)
  );
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [8:0] a, input logic [7:0] b);
    exp_t e;
    e.q = b == 0 ? 9'h1ff : a / b;
    e.r = b == 0 ? a[7:0] : 8'(a % b);
    e.z = b == 0;
    return e;
  endfunction
  always @(negedge ap_clk) begin
    if (!ap_rst && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("div_by_zero", div_by_zero, e.z);
      end
    end
  end
  task automatic send(input logic [8:0] a, input logic [7:0] b);
    int n = 0;
    while (!din_ready && n < 50) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("din_ready_before_send", din_ready, 1);
    sb.push_back(model(a, b));
    din0 = a;
    din1 = b;
    din_valid = 1'b1;
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    din0 = 9'($urandom);
    din1 = 8'($urandom);
  endtask
  task automatic op(input logic [8:0] a, input logic [7:0] b, input int hold, input bit thr);
    exp_t e;
    int n;
    e = model(a, b);
    dout_ready = hold > 0 ? 1'b0 : 1'b1;
    if (thr) repeat ($urandom_range(0, 2)) begin @(posedge ap_clk); #1; end
    send(a, b);
    n = 0;
    while (!dout_valid && n < 40) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("latency", n, b == 0 ? 1 : 9);
    for (int i = 0; i < hold; i++) begin
      chk("bp_quot", quot, e.q);
      chk("bp_rem", rem, e.r);
      chk("bp_din_ready", din_ready, 0);
      chk("bp_dout_valid", dout_valid, 1);
      @(posedge ap_clk); #1;
    end
    dout_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (dout_valid && n < 100) begin
      @(posedge ap_clk); #1;
      dout_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("handoff_dout_valid", dout_valid, 0);
    chk("handoff_din_ready", din_ready, 1);
  endtask
  initial begin
    int highs;
    ap_rst = 1'b1;
    din_valid = 1'b0;
    din0 = '0;
    din1 = '0;
    dout_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("rst_din_ready", din_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", div_by_zero, 0);
    op(300, 100, 0, 0);
    op(511, 1, 0, 0);
    op(7, 255, 0, 0);
    op(0, 5, 0, 0);
    op(510, 255, 0, 0);
    op(123, 0, 0, 0);
    op(10, 3, 0, 0);
    op(200, 7, 20, 0);
    send(400, 9);
    repeat (3) begin @(posedge ap_clk); #1; end
    ap_rst = 1'b1;
    sb.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("midrst_din_ready", din_ready, 1);
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_quot", quot, 0);
    chk("midrst_rem", rem, 0);
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      highs += int'(dout_valid);
      @(posedge ap_clk); #1;
    end
    chk("midrst_stale_valid", highs, 0);
    op(400, 9, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 7);
      b = $urandom_range(1, a == 0 ? 255 : (511 / a > 255 ? 255 : 511 / a));
      op(9'(a * b), 8'(b), 0, 1);
    end
    for (int i = 0; i < 1000; i++) op(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0, 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
